// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide unit for the RV32M funct3 set.
// Operands are reduced to magnitudes on issue. CALC runs one shift-add or
// shift-subtract step per cycle. DONE applies the sign fixup and registers the result.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            kill_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] data1_i,
  input  logic [XLEN-1:0] data2_i,
  output logic            busy_o,
  output logic            stall_o,
  output logic            valid_o,
  output logic [XLEN-1:0] data_o
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [2:0]        op_q;
  logic [CNT_W-1:0]  cnt;
  // acc_hi/acc_lo hold {product high, product low} for multiply and
  // {remainder, quotient/dividend} for divide.
  logic [XLEN-1:0]   acc_hi, acc_lo;
  logic [XLEN-1:0]   opb;
  logic              neg_res, neg_rem;
  logic              valid_q;
  logic [XLEN-1:0]   data_q;

  logic              accept;
  logic              a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_zero;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift, div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, result;

  // Issue-side decode: signedness per op, operand magnitudes and divide-by-zero.
  // MUL is treated as unsigned since its low half does not depend on signedness.
  always_comb begin
    a_signed = (op_i == OP_MULH) || (op_i == OP_MULHSU) ||
               (op_i == OP_DIV)  || (op_i == OP_REM);
    b_signed = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
    a_neg    = a_signed && data1_i[XLEN-1];
    b_neg    = b_signed && data2_i[XLEN-1];
    a_mag    = a_neg ? (~data1_i + 1'b1) : data1_i;
    b_mag    = b_neg ? (~data2_i + 1'b1) : data2_i;
    div_zero = op_i[2] && (data2_i == '0);
    accept   = (state == IDLE) && start_i && !kill_i;
  end

  // One radix-2 step. The restoring subtract cannot overflow bit XLEN because
  // the running remainder always stays below the divisor.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : {(XLEN+1){1'b0}});
    div_shift = {acc_hi, acc_lo[XLEN-1]};
    div_diff  = div_shift - {1'b0, opb};
    div_ge    = !div_diff[XLEN];
  end

  // Sign fixup and result selection, consumed while in DONE.
  // Divide-by-zero loads raw values with cleared sign flags, so they pass through unchanged.
  always_comb begin
    prod_fix = neg_res ? (~{acc_hi, acc_lo} + 1'b1) : {acc_hi, acc_lo};
    quot_fix = neg_res ? (~acc_lo + 1'b1) : acc_lo;
    rem_fix  = neg_rem ? (~acc_hi + 1'b1) : acc_hi;
    result   = '0;
    case (op_q)
      OP_MUL:                       result = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              result = quot_fix;
      OP_REM, OP_REMU:              result = rem_fix;
      default:                      result = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic: kill aborts CALC/DONE, and a zero divisor skips CALC.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = div_zero ? DONE : CALC;
      CALC: begin
        if (kill_i)                        state_next = IDLE;
        else if (cnt == CNT_W'(1))         state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch magnitudes and signs on accept, then iterate in CALC.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      op_q    <= '0;
      cnt     <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      opb     <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
    end else if (accept) begin
      op_q <= op_i;
      cnt  <= CNT_W'(XLEN);
      opb  <= b_mag;
      if (div_zero) begin
        acc_hi  <= data1_i;
        acc_lo  <= '1;
        neg_res <= 1'b0;
        neg_rem <= 1'b0;
      end else begin
        acc_hi  <= '0;
        acc_lo  <= a_mag;
        neg_res <= a_neg ^ b_neg;
        neg_rem <= a_neg;
      end
    end else if (state == CALC && !kill_i) begin
      cnt <= cnt - 1'b1;
      if (op_q[2]) begin
        acc_hi <= div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
        acc_lo <= {acc_lo[XLEN-2:0], div_ge};
      end else begin
        acc_hi <= mul_sum[XLEN:1];
        acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
      end
    end
  end

  // Output register: the strobe and result load on the edge leaving DONE unless killed.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= 1'b0;
      if (state == DONE && !kill_i) begin
        valid_q <= 1'b1;
        data_q  <= result;
      end
    end
  end

  assign busy_o  = (state != IDLE);
  assign stall_o = busy_o || accept;
  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table-driven directed vectors plus hand-written sequences
// for kill, reset, and busy-time start handling.
module tb_muldiv_unit;

  localparam int XLEN = 32;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b0;
  logic            start_i = 1'b0;
  logic            kill_i = 1'b0;
  logic [2:0]      op_i = 3'b000;
  logic [XLEN-1:0] data1_i = '0;
  logic [XLEN-1:0] data2_i = '0;
  logic            busy_o, stall_o, valid_o;
  logic [XLEN-1:0] data_o;

  int checks = 0;
  int failures = 0;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .kill_i  (kill_i),
    .op_i    (op_i),
    .data1_i (data1_i),
    .data2_i (data2_i),
    .busy_o  (busy_o),
    .stall_o (stall_o),
    .valid_o (valid_o),
    .data_o  (data_o)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk_i = ~clk_i;

  // Watchdog so the bench always ends even if something stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct {
    string           name;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] exp;
    int              lat;
  } vec_t;

  vec_t vecs[22];

  task automatic checkOutput(input string name, input logic [XLEN-1:0] actual,
                             input logic [XLEN-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Present one operation for a single cycle; returns #1 after the accepting edge.
  task automatic issueOp(input logic [2:0] op, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, output logic issue_stall);
    @(negedge clk_i);
    op_i    = op;
    data1_i = a;
    data2_i = b;
    start_i = 1'b1;
    #1;
    issue_stall = stall_o;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    op_i    = 3'($urandom);
    data1_i = $urandom;
    data2_i = $urandom;
  endtask

  // Issue an operation and wait (bounded) for its result strobe.
  task automatic applyStimulus(input logic [2:0] op, input logic [XLEN-1:0] a,
                               input logic [XLEN-1:0] b, output int lat,
                               output logic [XLEN-1:0] res, output logic issue_stall,
                               output logic stall_held);
    issueOp(op, a, b, issue_stall);
    lat = 0;
    stall_held = 1'b1;
    while (valid_o !== 1'b1 && lat < 100) begin
      stall_held &= stall_o;
      @(posedge clk_i);
      #1;
      lat++;
    end
    res = data_o;
  endtask

  initial begin
    int              lat;
    logic [XLEN-1:0] res, held;
    logic            s_issue, s_held;

    vecs[0]  = '{"MUL 7*-3",          3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 33};
    vecs[1]  = '{"MULH min*-1",       3'b001, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33};
    vecs[2]  = '{"MULHSU min*max",    3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33};
    vecs[3]  = '{"MULHU 8..*F..",     3'b011, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 33};
    vecs[4]  = '{"MULHU max*max",     3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    vecs[5]  = '{"MUL max*max",       3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33};
    vecs[6]  = '{"MULH -1*2",         3'b001, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 33};
    vecs[7]  = '{"MULHSU -1*max",     3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33};
    vecs[8]  = '{"DIV -7/2",          3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33};
    vecs[9]  = '{"REM -7/2",          3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33};
    vecs[10] = '{"DIVU F..9/2",       3'b101, 32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC, 33};
    vecs[11] = '{"REMU F..9/2",       3'b111, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 33};
    vecs[12] = '{"DIV 7/-2",          3'b100, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 33};
    vecs[13] = '{"REM 7/-2",          3'b110, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 33};
    vecs[14] = '{"DIV 5/0",           3'b100, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1};
    vecs[15] = '{"REM 5/0",           3'b110, 32'h00000005, 32'h00000000, 32'h00000005, 1};
    vecs[16] = '{"DIVU -7/0",         3'b101, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF, 1};
    vecs[17] = '{"REM -7/0",          3'b110, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 1};
    vecs[18] = '{"DIV overflow",      3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33};
    vecs[19] = '{"REM overflow",      3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33};
    vecs[20] = '{"DIVU 100/3",        3'b101, 32'h00000064, 32'h00000003, 32'h00000021, 33};
    vecs[21] = '{"REM min/3",         3'b110, 32'h80000000, 32'h00000003, 32'hFFFFFFFE, 33};

    // Reset state
    #12;
    checkOutput("reset busy_o", 32'(busy_o), 32'd0);
    checkOutput("reset valid_o", 32'(valid_o), 32'd0);
    checkOutput("reset data_o", data_o, 32'd0);
    checkOutput("reset stall_o", 32'(stall_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;

    // Table-driven vectors, issued back-to-back in the IDLE cycle after DONE
    for (int i = 0; i < 22; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, lat, res, s_issue, s_held);
      checkOutput({vecs[i].name, " data"}, res, vecs[i].exp);
      checkOutput({vecs[i].name, " latency"}, 32'(lat), 32'(vecs[i].lat));
      checkOutput({vecs[i].name, " issue stall"}, 32'(s_issue), 32'd1);
      checkOutput({vecs[i].name, " stall held"}, 32'(s_held), 32'd1);
    end

    // valid_o is a single-cycle pulse and data_o holds afterwards
    waitCycles(1);
    checkOutput("valid pulse width", 32'(valid_o), 32'd0);
    checkOutput("data held after valid", data_o, 32'hFFFFFFFE);
    checkOutput("idle busy", 32'(busy_o), 32'd0);

    // start_i pulsed while busy is ignored
    issueOp(3'b000, 32'h00000007, 32'hFFFFFFFD, s_issue);
    waitCycles(4);
    op_i = 3'b100; data1_i = 32'd5; data2_i = 32'd0; start_i = 1'b1;
    waitCycles(1);
    start_i = 1'b0;
    lat = 5;
    while (valid_o !== 1'b1 && lat < 100) begin
      waitCycles(1);
      lat++;
    end
    checkOutput("busy start latency", 32'(lat), 32'd33);
    checkOutput("busy start data", data_o, 32'hFFFFFFEB);
    held = data_o;

    // kill_i together with start_i in IDLE: nothing is accepted
    @(negedge clk_i);
    op_i = 3'b101; data1_i = 32'd100; data2_i = 32'd3;
    start_i = 1'b1; kill_i = 1'b1;
    #1;
    checkOutput("kill+start stall", 32'(stall_o), 32'd0);
    waitCycles(1);
    start_i = 1'b0; kill_i = 1'b0;
    checkOutput("kill+start busy", 32'(busy_o), 32'd0);

    // kill_i during CALC at cycle 10
    issueOp(3'b101, 32'd100, 32'd3, s_issue);
    waitCycles(9);
    checkOutput("pre-kill busy", 32'(busy_o), 32'd1);
    kill_i = 1'b1;
    waitCycles(1);
    kill_i = 1'b0;
    checkOutput("kill calc busy", 32'(busy_o), 32'd0);
    checkOutput("kill calc valid", 32'(valid_o), 32'd0);
    checkOutput("kill calc data", data_o, held);
    applyStimulus(3'b101, 32'd100, 32'd3, lat, res, s_issue, s_held);
    checkOutput("after kill latency", 32'(lat), 32'd33);
    checkOutput("after kill data", res, 32'h00000021);
    held = res;

    // kill_i during DONE suppresses the strobe and keeps data_o
    issueOp(3'b000, 32'd6, 32'd7, s_issue);
    waitCycles(32);
    checkOutput("done busy", 32'(busy_o), 32'd1);
    kill_i = 1'b1;
    waitCycles(1);
    kill_i = 1'b0;
    checkOutput("kill done valid", 32'(valid_o), 32'd0);
    checkOutput("kill done data", data_o, held);
    checkOutput("kill done busy", 32'(busy_o), 32'd0);

    // Asynchronous reset mid-CALC, applied away from the clock edge
    issueOp(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, s_issue);
    waitCycles(10);
    #3;
    rst_i = 1'b0;
    #1;
    checkOutput("async reset busy", 32'(busy_o), 32'd0);
    checkOutput("async reset valid", 32'(valid_o), 32'd0);
    checkOutput("async reset data", data_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    waitCycles(40);
    checkOutput("post reset valid", 32'(valid_o), 32'd0);
    checkOutput("post reset busy", 32'(busy_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multi-cycle multiply/divide unit implementing the full RV32M funct3 set; parametrised successor to the single-cycle ALU MUL path.
- Sits in EX beside the ALU. The core issues an operation with start_i.
- The unit raises stall_o to drive PCWrite low until valid_o pulses. The result is then muxed into the writeback path.

Parameters:
- XLEN, 32, operand/result width in bits; must be >= 4 and even.
- CNT_W, $clog2(XLEN)+1, iteration counter width; derived, not overridden.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- start_i  input  1  issue request; sampled only in IDLE.
- kill_i  input  1  abort/flush of the in-flight operation.
- op_i  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- data1_i  input  XLEN  rs1 operand.
- data2_i  input  XLEN  rs2 operand.
- busy_o  output  1  operation in flight (CALC or DONE).
- stall_o  output  1  combinational: busy_o | (IDLE & start_i & ~kill_i).
- valid_o  output  1  one-cycle result strobe.
- data_o  output  XLEN  result; held stable until the next valid_o.

Behaviour:
- Reset (rst_i low, asynchronous):
  - state = IDLE.
  - busy_o = 0, valid_o = 0, data_o = 0.
  - Counter, accumulators and latched op all cleared.
- States IDLE, CALC, DONE.
- IDLE:
  - start_i=1 & kill_i=0 at an edge: latch op_i. Latch operand magnitudes (signed ops take |x|; MULHSU makes only rs1 signed). Latch the result sign. Load counter = XLEN. Go to CALC.
  - Exception: DIV/DIVU/REM/REMU with data2_i == 0 skip CALC and go straight to DONE.
- CALC:
  - One radix-2 step per cycle; counter decrements.
  - Multiply: shift-add into a 2*XLEN product.
  - Divide: restoring shift-subtract; quotient and remainder each XLEN wide.
  - When counter reaches 1, the next edge goes to DONE. CALC therefore lasts exactly XLEN cycles.
- DONE:
  - Apply sign fixup:
    - Product: negate the full 2*XLEN value if the sign flag is set.
    - Quotient: negate if the operand signs differ.
    - Remainder: takes the sign of the dividend.
  - Register data_o and assert valid_o for this one cycle.
  - Next edge goes to IDLE.
- Latency: valid_o rises XLEN+1 cycles after the accepting edge (33 for XLEN=32). The divide-by-zero path takes 1 cycle.
- Result selection:
  - MUL = product[XLEN-1:0].
  - MULH/MULHSU/MULHU = product[2*XLEN-1:XLEN].
  - DIV/DIVU = quotient.
  - REM/REMU = remainder.
- Divide-by-zero:
  - DIV/DIVU return all ones.
  - REM/REMU return data1_i unchanged.
- Signed overflow (data1 = -2^(XLEN-1), data2 = -1):
  - DIV returns -2^(XLEN-1).
  - REM returns 0.
  - Must fall out of the datapath or be special-cased; no trap.
- Busy rules:
  - start_i while busy is ignored; no queueing.
  - Operand/op inputs are don't-care after the accepting edge.
- kill_i:
  - In CALC or DONE: the next edge goes to IDLE.
  - valid_o is suppressed in that cycle and data_o keeps its previous value.
  - kill_i with start_i in IDLE: kill wins, nothing is accepted.
- Back-to-back: a new start_i is accepted in the IDLE cycle immediately after DONE. There is a minimum one IDLE cycle between operations.
- Reset mid-operation aborts immediately to the reset state; no valid_o is produced.

Test Plan:
- MUL 7 × -3 (0x00000007, 0xFFFFFFFD), XLEN=32 -> valid_o exactly 33 cycles after accept, data_o=0xFFFFFFEB; stall_o high from the issue cycle through DONE.
- MULH/MULHSU/MULHU with 0x80000000 × 0xFFFFFFFF -> 0x00000000, 0x80000000, 0x7FFFFFFF respectively.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC; REMU -> 1.
- DIV 5/0 -> 0xFFFFFFFF one cycle after accept; REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
- Start DIVU 100/3, then assert kill_i at cycle 10 -> no valid_o, data_o unchanged, IDLE next cycle. A new start the following cycle completes to 33.
- Drop rst_i low mid-CALC, asynchronously off-edge -> busy_o, valid_o and data_o are 0 immediately. start_i pulses during busy -> ignored, and the original result is unchanged.
